// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, an NZCV status register and a
// multi-cycle shift-add multiplier.
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             s_bit,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             out_err,
    output logic [3:0]       flags
);

    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_MVN = 4'b1001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_ORR = 4'b0111;
    localparam logic [3:0] OP_EOR = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1010;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] result_nx;
    logic             out_err_nx;
    logic [3:0]       flags_nx;
    logic [WIDTH-1:0] mcand, mcand_nx;
    logic [WIDTH-1:0] mplier, mplier_nx;
    logic [WIDTH-1:0] acc, acc_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             mul_s, mul_s_nx;

    logic             accept;
    logic [WIDTH-1:0] addend;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             v_ovf;
    logic [WIDTH-1:0] logic_res;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // Shared adder: subtraction is in1 + ~in2 + carry-in, carry-in from C for ADC/SBC
    always_comb begin
        addend = in2;
        cin    = 1'b0;
        case (op)
            OP_ADC: cin = flags[1];
            OP_SUB: begin
                addend = ~in2;
                cin    = 1'b1;
            end
            OP_SBC: begin
                addend = ~in2;
                cin    = flags[1];
            end
            default: ;
        endcase
        sum   = {1'b0, in1} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};
        v_ovf = (in1[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
    end

    always_comb begin
        logic_res = in2;
        case (op)
            OP_MVN:  logic_res = ~in2;
            OP_AND:  logic_res = in1 & in2;
            OP_ORR:  logic_res = in1 | in2;
            OP_EOR:  logic_res = in1 ^ in2;
            default: ;
        endcase
    end

    // Next-state and datapath updates; an accepted request overrides the hold/step values
    always_comb begin
        state_nx   = state;
        result_nx  = result;
        out_err_nx = out_err;
        flags_nx   = flags;
        mcand_nx   = mcand;
        mplier_nx  = mplier;
        acc_nx     = acc;
        cnt_nx     = cnt;
        mul_s_nx   = mul_s;

        case (state)
            MUL_BUSY: begin
                acc_nx    = mplier[0] ? (acc + mcand) : acc;
                mcand_nx  = mcand << 1;
                mplier_nx = mplier >> 1;
                cnt_nx    = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_nx   = DONE;
                    result_nx  = acc_nx;
                    out_err_nx = 1'b0;
                    if (mul_s) begin
                        flags_nx[3:2] = {acc_nx[WIDTH-1], (acc_nx == '0)};
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            state_nx   = DONE;
            out_err_nx = 1'b0;
            case (op)
                OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                    result_nx = sum[WIDTH-1:0];
                    if (s_bit) begin
                        flags_nx = {sum[WIDTH-1], (sum[WIDTH-1:0] == '0), sum[WIDTH], v_ovf};
                    end
                end
                OP_MOV, OP_MVN, OP_AND, OP_ORR, OP_EOR: begin
                    result_nx = logic_res;
                    if (s_bit) begin
                        flags_nx[3:2] = {logic_res[WIDTH-1], (logic_res == '0)};
                    end
                end
                OP_MUL: begin
                    state_nx  = MUL_BUSY;
                    cnt_nx    = '0;
                    mcand_nx  = in1;
                    mplier_nx = in2;
                    acc_nx    = '0;
                    mul_s_nx  = s_bit;
                end
                default: begin
                    result_nx  = '0;
                    out_err_nx = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            result  <= '0;
            out_err <= 1'b0;
            flags   <= 4'b0000;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            mul_s   <= 1'b0;
        end else begin
            state   <= state_nx;
            result  <= result_nx;
            out_err <= out_err_nx;
            flags   <= flags_nx;
            mcand   <= mcand_nx;
            mplier  <= mplier_nx;
            acc     <= acc_nx;
            cnt     <= cnt_nx;
            mul_s   <= mul_s_nx;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a driver pushes expected responses on acceptance,
// a monitor compares every presented result, latency and handshake.
module tb_alu_seq;

    localparam int unsigned W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = 4'd0;
    logic         s_bit = 1'b0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         out_err;
    logic [3:0]   flags;

    alu_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .s_bit     (s_bit),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_err   (out_err),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        err;
        logic [3:0]  flg;
        int          lat;
        int          acc;
        logic [3:0]  op;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [3:0] m_flags = 4'b0000;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: ARM semantics from plain integer arithmetic
    function automatic void model(input logic [3:0] o, input logic s, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] res, output logic err);
        logic [63:0] u;
        longint      sa, sb, sv;
        logic        c, v, arith, cin, brw;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sv = 0;
        u = 64'd0;
        c = 1'b0; v = 1'b0; arith = 1'b0; err = 1'b0; res = 32'd0;
        cin = m_flags[1];
        brw = ~cin;
        case (o)
            4'b0001: res = b;
            4'b1001: res = ~b;
            4'b0110: res = a & b;
            4'b0111: res = a | b;
            4'b1000: res = a ^ b;
            4'b0010: begin
                u = 64'(a) + 64'(b); res = u[31:0]; c = u[32]; sv = sa + sb; arith = 1'b1;
            end
            4'b0011: begin
                u = 64'(a) + 64'(b) + 64'(cin); res = u[31:0]; c = u[32];
                sv = sa + sb + (cin ? 64'sd1 : 64'sd0); arith = 1'b1;
            end
            4'b0100: begin
                res = a - b; c = (a >= b); sv = sa - sb; arith = 1'b1;
            end
            4'b0101: begin
                res = a - b - 32'(brw); c = (64'(a) >= 64'(b) + 64'(brw));
                sv = sa - sb - (brw ? 64'sd1 : 64'sd0); arith = 1'b1;
            end
            4'b1010: begin
                u = 64'(a) * 64'(b); res = u[31:0];
            end
            default: err = 1'b1;
        endcase
        if (arith) v = (sv > SMAX) || (sv < SMIN);
        if (!err && s) begin
            m_flags[3] = res[31];
            m_flags[2] = (res == 32'd0);
            if (arith) begin
                m_flags[1] = c;
                m_flags[0] = v;
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queue head
    initial begin : monitor
        bit rst_prev = 1'b0;
        bit seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rst_prev = 1'b1;
                seen = 1'b0;
            end else begin
                if (rst_prev) begin
                    chk("reset out_valid", 32'(out_valid), 32'd0);
                    chk("reset in_ready", 32'(in_ready), 32'd1);
                    chk("reset result", result, 32'd0);
                    chk("reset out_err", 32'(out_err), 32'd0);
                    chk("reset flags", 32'(flags), 32'd0);
                    rst_prev = 1'b0;
                end
                if (out_valid) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected out_valid: got result %h with nothing expected", result);
                    end else begin
                        if (!seen) begin
                            chk($sformatf("latency op=%h", q[0].op), 32'(cyc - q[0].acc), 32'(q[0].lat));
                            seen = 1'b1;
                        end
                        chk($sformatf("result op=%h", q[0].op), result, q[0].res);
                        chk($sformatf("out_err op=%h", q[0].op), 32'(out_err), 32'(q[0].err));
                        chk($sformatf("flags op=%h", q[0].op), 32'(flags), 32'(q[0].flg));
                        chk("in_ready while done", 32'(in_ready), 32'(out_ready));
                        if (out_ready) begin
                            void'(q.pop_front());
                            seen = 1'b0;
                        end
                    end
                end else begin
                    chk("in_ready idle/busy", 32'(in_ready), 32'(q.size() == 0));
                end
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input bit rnd, input bit dir, input logic [31:0] eres,
                         input logic [3:0] eflg, input logic eerr);
        exp_t e;
        int   acc_c;
        bit   done;
        done  = 1'b0;
        acc_c = 0;
        model(o, s, a, b, e.res, e.err);
        e.flg = m_flags;
        if (dir) begin
            e.res = eres;
            e.flg = eflg;
            e.err = eerr;
        end
        e.op  = o;
        e.lat = (o == 4'b1010) ? int'(W) + 1 : 1;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        op        = o;
        s_bit     = s;
        in1       = a;
        in2       = b;
        out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc_c = cyc;
                done  = 1'b1;
            end else begin
                @(posedge clk); #1;
                if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            end
        end
        if (!done) begin
            $display("FAIL accept timeout: in_ready stayed 0 for op %h", o);
            $fatal(1);
        end
        e.acc = acc_c;
        @(posedge clk); #1;
        q.push_back(e);
        in_valid = 1'b0;
        in1 = $urandom;
        in2 = $urandom;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            $display("FAIL drain timeout: %0d results never presented", q.size());
            $fatal(1);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin : driver
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        issue(4'b0010, 1, 32'hFFFF_FFFF, 32'h1, 0, 1, 32'h0, 4'b0110, 0);
        drain();
        issue(4'b0010, 1, 32'h8000_0000, 32'h8000_0000, 0, 1, 32'h0, 4'b0111, 0);
        drain();
        issue(4'b0011, 0, 32'd5, 32'd7, 0, 1, 32'd13, 4'b0111, 0);
        drain();
        issue(4'b0100, 1, 32'd3, 32'd5, 0, 1, 32'hFFFF_FFFE, 4'b1000, 0);
        drain();
        issue(4'b0101, 1, 32'd10, 32'd3, 0, 1, 32'd6, 4'b0010, 0);
        drain();
        issue(4'b1010, 1, 32'h0001_0003, 32'h0000_0005, 0, 1, 32'h0005_000F, 4'b0010, 0);
        drain();

        // Held MOV under backpressure, then consumed back-to-back with an MVN
        issue(4'b0001, 0, 32'h0, 32'hA5, 0, 1, 32'hA5, 4'b0010, 0);
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        issue(4'b1001, 0, 32'h0, 32'h0, 0, 1, 32'hFFFF_FFFF, 4'b0010, 0);
        drain();

        issue(4'b1111, 1, 32'h1234, 32'h5678, 0, 1, 32'h0, 4'b0010, 1);
        drain();

        // Reset in the middle of a multiply discards it
        issue(4'b1010, 1, 32'h0000_0003, 32'h0000_0007, 0, 0, 32'h0, 4'h0, 0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        q.delete();
        m_flags = 4'b0000;
        @(posedge clk);
        #1 rst = 1'b0;

        for (int n = 0; n < 250; n++) begin
            int idle;
            idle = $urandom_range(0, 2);
            for (int k = 0; k < idle; k++) begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(0, 1) != 0);
            end
            issue(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), pick(), pick(),
                  1, 0, 32'h0, 4'h0, 0);
        end
        drain();
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the core's combinational ALU.
- Accepts one operation per valid/ready handshake and holds the result until it is consumed.
- Keeps an internal NZCV status register, which makes ADC/SBC flag-correct with true ARM carry/overflow semantics.
- Adds a multi-cycle shift-add MUL. Sits between the EXE-stage operand muxes and the EXE/MEM pipeline register.

Parameters:
- WIDTH, 32, datapath width of in1, in2 and result (must be >= 4).
- CNT_W, 6, width of the MUL iteration counter (must satisfy 2^CNT_W > WIDTH).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted this cycle when in_valid && in_ready.
- op  input  4  opcode: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, MUL 1010; all others undefined.
- s_bit  input  1  update NZCV for this operation.
- in1  input  WIDTH  operand 1 (Rn).
- in2  input  WIDTH  operand 2 (shifter output).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result when out_valid && out_ready.
- result  output  WIDTH  registered result.
- out_err  output  1  held result came from an undefined opcode.
- flags  output  4  status register {N,Z,C,V}.

Behaviour:
Reset:
- state=IDLE; in_ready=1; out_valid=0; result=0; out_err=0; flags=4'b0000; MUL counter and accumulators cleared.
- rst wins over every other event, including an in-flight MUL, which is discarded.

FSM (IDLE, MUL_BUSY, DONE):
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept in IDLE, or in DONE on the same cycle the held result is consumed (back-to-back).
  - Non-MUL op: next state DONE; result and flags are written on that edge. Latency is 1 cycle: out_valid is high the cycle after acceptance.
  - MUL: next state MUL_BUSY, counter=0. Multiplicand and multiplier are latched on acceptance; later changes to in1/in2 do not affect the product.
- MUL_BUSY:
  - One shift-add step per cycle.
  - After WIDTH steps, go to DONE. result = low WIDTH bits of in1*in2 (unsigned; identical to signed for the low half).
  - Latency is WIDTH+1 cycles from acceptance to out_valid. in_ready=0 throughout.
- DONE:
  - out_valid=1; result, out_err and flags are stable.
  - On out_ready: go to IDLE, or restart if a new request is accepted on the same cycle.
  - With out_ready=0, hold indefinitely. Backpressure must never corrupt result or flags.

Arithmetic (WIDTH+1-bit internal sums; cin = flags.C sampled at acceptance):
- MOV: in2. MVN: ~in2. AND/ORR/EOR: bitwise.
- ADD: in1+in2; C = carry out; V = (in1[W-1]==in2[W-1]) && (res[W-1]!=in1[W-1]).
- ADC: in1+in2+cin; C and V as for ADD.
- SUB: in1+~in2+1; C = NOT borrow (1 when in1>=in2 unsigned); V = (in1[W-1]!=in2[W-1]) && (res[W-1]!=in1[W-1]).
- SBC: in1+~in2+cin (ARM: in1-in2-!C); C and V as for SUB.

Flags (written on entry to DONE, only if s_bit latched =1):
- Arithmetic ops: N = res[W-1]; Z = (res==0); C and V as above.
- Logic/MOV/MVN/MUL: update N and Z only; C and V are preserved.
- Undefined op: result=0, out_err=1, flags unchanged regardless of s_bit; the FSM still passes through DONE with 1-cycle latency.
- s_bit=0: flags unchanged.
- Flags visible at the flags output equal the last completed flag-setting op. The next ADC/SBC sees them because ops are serialised.

Test Plan:
- Reset then ADD, s=1: in1=32'hFFFF_FFFF, in2=1 -> next cycle out_valid=1, result=0, flags=0110 (Z,C).
- Carry chain, ADD s=1 then ADC s=0:
  - ADD: in1=32'h8000_0000, in2=32'h8000_0000 -> result=0, flags=0111 (Z,C,V).
  - ADC: in1=5, in2=7 -> result=13, flags still 0111.
- Subtraction, SUB s=1 then SBC s=1 with C=0:
  - SUB: 3-5 -> result=32'hFFFF_FFFE, flags=1000.
  - SBC: in1=10, in2=3 -> result=6, flags=0010.
- MUL: in1=32'h0001_0003, in2=32'h0000_0005, s=1 -> in_ready=0 for 32 cycles; out_valid asserts exactly 33 cycles after acceptance; result=32'h0005_000F; N=0, Z=0; C and V unchanged.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles after a MOV of 32'hA5 -> result holds 32'hA5, in_ready=0.
  - Raise out_ready together with in_valid (op MVN, in2=0) -> next cycle result=32'hFFFF_FFFF.
- Undefined op 4'b1111 with s=1 -> result=0, out_err=1, flags unchanged.
- rst asserted mid-MUL (cycle 10) -> next cycle state=IDLE, out_valid=0, flags=0000.
